// File: rtl/fetch_queue_pkg.sv
// Shared types for the fetch queue: FSM states, halt opcode and the
// default-configuration entry layout.
package fetch_queue_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    WAIT   = 2'd1,
    HALTED = 2'd2
  } fetch_state_t;

  localparam logic [4:0] HALT_OPC_DEF = 5'b00000;
  localparam int         PC_W_DEF     = 16;
  localparam int         INSTR_W_DEF  = 16;

  // Entry layout at the default widths; the top rebuilds the same layout
  // from its own parameters so non-default configurations stay consistent.
  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc;
    logic [PC_W_DEF-1:0]    pc_2;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO with flush and occupancy count.
// Head is read straight out of the storage registers, so a push at edge N
// is visible at the head from edge N when the FIFO was empty.
module fetch_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and count bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage write; contents need no reset since the head is qualified by count.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // The producer's credit scheme must never push into a full FIFO.
  a_no_push_full: assert property (@(posedge clk) disable iff (!rst) !(push && full));

endmodule

// File: rtl/fetch_queue.sv
// Fetch stage: owns the PC, issues single-outstanding instruction reads and
// buffers responses in a prefetch FIFO drained by decode via valid/ready.
// Redirect flushes the queue and discards any in-flight response.
// Optional macro FETCH_BYPASS_EN: a response arriving to an empty FIFO is
// presented combinationally and skips the FIFO if accepted that cycle.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int             PC_W     = 16,
  parameter int             INSTR_W  = 16,
  parameter int             DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [4:0]     HALT_OPC = HALT_OPC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  output logic                       mem_req,
  output logic [PC_W-1:0]            mem_addr,
  input  logic                       mem_done,
  input  logic [INSTR_W-1:0]         mem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [INSTR_W-1:0]         out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic [PC_W-1:0]            out_pc_2,
  output logic                       halt_seen,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_2;
  } entry_t;

  fetch_state_t   state;
  logic [PC_W-1:0] pc, req_addr;
  logic           pend, drop;
  logic           resp_ok, resp_halt, credit_ok, bypass_hit;
  logic           fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CW-1:0]  fifo_count;
  entry_t         push_entry, head_entry, out_entry;

  // A response is kept only if it answers a live request and no redirect races it.
  assign resp_ok    = mem_done && pend && !drop && !redirect;
  assign resp_halt  = (mem_rdata[INSTR_W-1 -: 5] == HALT_OPC);
  assign push_entry = '{instr: mem_rdata, pc: req_addr, pc_2: req_addr + PC_W'(2)};

  // Credit rule: never have more requests in flight than free FIFO slots.
  assign credit_ok = (int'(fifo_count) + int'(pend)) < DEPTH;
  assign mem_req   = rst && (state == RUN) && !pend && !drop && !redirect && credit_ok;
  assign mem_addr  = pc;

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = resp_ok && fifo_empty;
  assign out_entry  = bypass_hit ? push_entry : head_entry;
`else
  assign bypass_hit = 1'b0;
  assign out_entry  = head_entry;
`endif

  assign out_valid = !fifo_empty || bypass_hit;
  assign fifo_push = resp_ok && !(bypass_hit && out_ready);
  assign fifo_pop  = out_valid && out_ready && !fifo_empty && !redirect;
  assign occupancy = fifo_count;

  // Head fields read as zero whenever nothing is presented.
  assign out_instr = out_valid ? out_entry.instr : '0;
  assign out_pc    = out_valid ? out_entry.pc    : '0;
  assign out_pc_2  = out_valid ? out_entry.pc_2  : '0;

  fetch_fifo #(
    .W     ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (fifo_push),
    .push_data (push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Fetch FSM: request issue, response tracking, halt and redirect handling.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      req_addr  <= '0;
      pend      <= 1'b0;
      drop      <= 1'b0;
      halt_seen <= 1'b0;
    end else if (redirect) begin
      state     <= RUN;
      pc        <= redirect_pc;
      halt_seen <= 1'b0;
      // An in-flight read is marked for discard; one landing now is simply lost.
      if (pend && !mem_done) begin
        drop <= 1'b1;
      end else begin
        drop <= 1'b0;
        pend <= 1'b0;
      end
    end else begin
      if (mem_done && pend && drop) begin
        drop <= 1'b0;
        pend <= 1'b0;
      end
      unique case (state)
        RUN: begin
          if (mem_req) begin
            req_addr <= pc;
            pc       <= pc + PC_W'(2);
            pend     <= 1'b1;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (resp_ok) begin
            pend <= 1'b0;
            if (resp_halt) begin
              state     <= HALTED;
              halt_seen <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        HALTED: ;
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a memory model answers reads with
// configurable latency, a reference model tracks the expected fetch stream,
// and an independent monitor checks every entry decode accepts.
module tb_fetch_queue;

  localparam int PC_W = 16, INSTR_W = 16, DEPTH = 4;

  logic               clk = 1'b0, rst = 1'b0, redirect = 1'b0;
  logic [PC_W-1:0]    redirect_pc = '0;
  logic               mem_req, mem_done = 1'b0;
  logic [PC_W-1:0]    mem_addr;
  logic [INSTR_W-1:0] mem_rdata = '0;
  logic               out_valid, out_ready = 1'b0, halt_seen;
  logic [INSTR_W-1:0] out_instr;
  logic [PC_W-1:0]    out_pc, out_pc_2;
  logic [2:0]         occupancy;

  always #5 clk = ~clk;

  fetch_queue #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(16'h0000), .HALT_OPC(5'b00000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_done(mem_done), .mem_rdata(mem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .out_pc_2(out_pc_2), .halt_seen(halt_seen), .occupancy(occupancy)
  );

  typedef struct { logic [15:0] instr; logic [15:0] pc; } exp_t;
  exp_t exp_q[$];

  int checks = 0, errors = 0;
  int req_count = 0, pop_count = 0;
  int lat_min = 1, lat_max = 1, mem_cnt = 0;
  bit outstanding = 0, dropped = 0, halted = 0, saw_wrap = 0;
  logic [15:0] exp_addr = '0, req_addr_m = '0, mem_busy_addr = '0;
  logic [15:0] last_req_addr = 16'hFFFF, halt_addr = 16'h0FFF;

  // Memory image: every word has a non-halt opcode except at halt_addr.
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [4:0] opc;
    if (a == halt_addr) return {5'b00000, 11'h2A5};
    opc = a[7:3] ^ 5'h0B;
    if (opc == 5'b0) opc = 5'h1F;
    return {opc, a[10:0] ^ 11'h5A5};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b0; redirect = 1'b0; out_ready = 1'b0;
    repeat (2) step();
    rst = 1'b1;
  endtask

  // Reference model: per-cycle state of the fetch stream and expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      outstanding = 0; dropped = 0; halted = 0;
      exp_addr = 16'h0000; mem_cnt = 0;
    end else begin
      chk("occupancy", occupancy, exp_q.size());
      chk("out_valid", out_valid, exp_q.size() != 0);
      chk("halt_seen", halt_seen, halted);
      chk("mem_req", mem_req, !halted && !outstanding && !redirect && (exp_q.size() < DEPTH));
      if (mem_done && outstanding && !redirect) begin
        outstanding = 0;
        if (dropped) dropped = 0;
        else begin
          exp_q.push_back('{instr: mem_word(req_addr_m), pc: req_addr_m});
          if (mem_word(req_addr_m)[15:11] == 5'b0) halted = 1;
        end
      end
      if (redirect) begin
        exp_q.delete();
        halted = 0;
        exp_addr = redirect_pc;
        if (outstanding && !mem_done) dropped = 1;
        else begin outstanding = 0; dropped = 0; end
      end
      if (mem_req) begin
        chk("mem_addr", mem_addr, exp_addr);
        last_req_addr = mem_addr;
        req_count++;
        mem_busy_addr = mem_addr;
        mem_cnt = $urandom_range(lat_max, lat_min);
        if (!redirect) begin
          outstanding = 1;
          req_addr_m = exp_addr;
          exp_addr = exp_addr + 16'd2;
        end
      end
    end
  end

  // Memory responder: raises mem_done after the sampled latency.
  always @(posedge clk) begin
    #1;
    mem_done = 1'b0;
    if (mem_cnt > 0) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        mem_done = 1'b1;
        mem_rdata = mem_word(mem_busy_addr);
      end
    end
  end

  // Monitor: every accepted head entry is compared against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (rst && out_valid && out_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_empty: got pc %0h expected no entry", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("out_instr", out_instr, e.instr);
        chk("out_pc", out_pc, e.pc);
        chk("out_pc_2", out_pc_2, 16'(e.pc + 16'd2));
        pop_count++;
        if (out_pc == 16'hFFFE && out_pc_2 == 16'h0000) saw_wrap = 1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n, n0;
    // Reset state
    repeat (2) @(posedge clk); #2;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_halt_seen", halt_seen, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_instr", out_instr, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_pc_2", out_pc_2, 0);
    rst = 1'b1;

    // Streaming at latency 1 with decode always ready
    lat_min = 1; lat_max = 1; out_ready = 1'b1;
    repeat (12) step();
    chk("A_pops", pop_count >= 4, 1);

    // Backpressure fills the queue and stops requests
    do_reset();
    out_ready = 1'b0;
    n = 0;
    while (occupancy != 3'd4 && n < 60) begin step(); n++; end
    chk("B_full", occupancy, 4);
    n0 = req_count;
    repeat (6) step();
    chk("B_stall", req_count - n0, 0);
    out_ready = 1'b1; step(); out_ready = 1'b0;
    n0 = req_count;
    repeat (8) step();
    chk("B_one_req", req_count - n0, 1);
    chk("B_refill", occupancy, 4);

    // Redirect while a 3-cycle read of 0x0008 is pending
    do_reset();
    lat_min = 3; lat_max = 3; out_ready = 1'b1;
    last_req_addr = 16'hFFFF;
    n = 0;
    while (last_req_addr != 16'h0008 && n < 100) begin step(); n++; end
    chk("C_found", last_req_addr, 16'h0008);
    redirect = 1'b1; redirect_pc = 16'h0100; step(); redirect = 1'b0;
    n0 = req_count; n = 0;
    while (req_count == n0 && n < 20) begin step(); n++; end
    chk("C_next_addr", last_req_addr, 16'h0100);
    repeat (10) step();

    // Redirect in the same cycle as a response
    do_reset();
    lat_min = 2; lat_max = 2; out_ready = 1'b1;
    n = 0;
    while (mem_done != 1'b1 && n < 20) begin step(); n++; end
    chk("D_done_seen", mem_done, 1);
    redirect = 1'b1; redirect_pc = 16'h0040; step(); redirect = 1'b0;
    n0 = req_count; n = 0;
    while (req_count == n0 && n < 20) begin step(); n++; end
    chk("D_next_addr", last_req_addr, 16'h0040);
    repeat (10) step();

    // Halt opcode at 0x000A, then resume by redirect
    halt_addr = 16'h000A;
    do_reset();
    lat_min = 1; lat_max = 1; out_ready = 1'b1;
    repeat (40) step();
    chk("E_halt", halt_seen, 1);
    chk("E_last_addr", last_req_addr, 16'h000A);
    chk("E_drained", occupancy, 0);
    n0 = req_count;
    redirect = 1'b1; redirect_pc = 16'h0020; step(); redirect = 1'b0;
    chk("E_cleared", halt_seen, 0);
    repeat (10) step();
    chk("E_resume", req_count > n0, 1);

    // PC wrap at 0xFFFE
    redirect = 1'b1; redirect_pc = 16'hFFFE; step(); redirect = 1'b0;
    repeat (12) step();
    chk("F_wrap", saw_wrap, 1);

    // Randomised traffic
    halt_addr = {10'b0, 5'($urandom_range(31, 0)), 1'b0};
    do_reset();
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 2500; i++) begin
      out_ready = ($urandom_range(3, 0) != 0);
      redirect = ($urandom_range(19, 0) == 0);
      redirect_pc = ($urandom_range(7, 0) == 0) ? 16'hFFF8 : {10'b0, 5'($urandom_range(31, 0)), 1'b0};
      step();
    end
    redirect = 1'b0; out_ready = 1'b1;
    repeat (20) step();
    chk("G_pops", pop_count > 200, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
